sig_req_arbiter: RTL and testbench

Shares one multi-cycle sigmoid unit (K-segment, IEEE-754 single precision, start/x_in -> valid/y_out) among NREQ requesters. Requesters are served round-robin. Each accepted operand is issued to the unit with a start pulse. Every result is routed back, tagged with the originating requester ID. Sits between activation-layer lanes and a single sig_*_hw instance.

---
 rtl/sig_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_sig_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_req_arbiter.sv
// Round-robin arbiter sharing one pipelined sigmoid unit among NREQ requesters.
// Results come back in issue order and are tagged with the originating requester ID.
module sig_req_arbiter #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned DWIDTH       = 32,
   parameter int unsigned IDW          = 2,
   parameter int unsigned MAX_INFLIGHT = 8,
   parameter int unsigned CW           = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DWIDTH-1:0] req_x,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   drain,
   output logic                   sig_start,
   output logic [DWIDTH-1:0]      sig_x,
   input  logic [DWIDTH-1:0]      sig_y,
   input  logic                   sig_valid,
   output logic                   resp_valid,
   output logic [IDW-1:0]         resp_id,
   output logic [DWIDTH-1:0]      resp_y,
   output logic [CW-1:0]          inflight,
   output logic                   busy,
   output logic                   drain_done,
   output logic                   err_unexp
);
   localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [IDW-1:0]    rr_q, rr_d;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              sig_start_q, sig_start_d;
   logic [DWIDTH-1:0] sig_x_q, sig_x_d;
   logic              resp_valid_q, resp_valid_d;
   logic [IDW-1:0]    resp_id_q, resp_id_d;
   logic [DWIDTH-1:0] resp_y_q, resp_y_d;
   logic              err_unexp_q, err_unexp_d;
   logic [IDW-1:0]    tag_mem_q [MAX_INFLIGHT];

   logic           hs;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] idx;
   logic           fifo_empty;
   logic           pop;

   // First valid requester at or after the rr pointer, wrapping; credit is the registered count.
   always_comb begin
      req_ready = '0;
      hs        = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      if (state_q == StRun && inflight_q < CW'(MAX_INFLIGHT)) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(rr_q) + k) % NREQ);
            if (!hs && req_valid[idx]) begin
               hs             = 1'b1;
               gnt_id         = idx;
               req_ready[idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      fifo_empty   = (inflight_q == '0);
      pop          = sig_valid & ~fifo_empty;

      rr_d         = rr_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      sig_start_d  = hs;
      sig_x_d      = sig_x_q;
      resp_valid_d = pop;
      resp_id_d    = resp_id_q;
      resp_y_d     = resp_y_q;
      err_unexp_d  = err_unexp_q | (sig_valid & fifo_empty);
      inflight_d   = inflight_q + CW'(hs) - CW'(pop);

      if (hs) begin
         rr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
         wr_ptr_d = wr_ptr_q + PW'(1);
         sig_x_d  = req_x[32'(gnt_id)*DWIDTH +: DWIDTH];
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PW'(1);
         resp_id_d = tag_mem_q[rd_ptr_q];
         resp_y_d  = sig_y;
      end

      state_d = state_q;
      unique case (state_q)
         StRun:   if (drain) state_d = StDrain;
         StDrain: begin
            if (!drain) state_d = StRun;
            else if (inflight_q == '0 && !sig_start_q) state_d = StDone;
         end
         StDone:  if (!drain) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StRun;
         rr_q         <= '0;
         inflight_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         sig_start_q  <= 1'b0;
         sig_x_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_y_q     <= '0;
         err_unexp_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         inflight_q   <= inflight_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         sig_start_q  <= sig_start_d;
         sig_x_q      <= sig_x_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_y_q     <= resp_y_d;
         err_unexp_q  <= err_unexp_d;
      end
   end

   // Tag storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (hs) tag_mem_q[wr_ptr_q] <= gnt_id;
   end

   assign sig_start  = sig_start_q;
   assign sig_x      = sig_x_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_y     = resp_y_q;
   assign inflight   = inflight_q;
   assign busy       = (inflight_q != '0) | sig_start_q;
   assign drain_done = (state_q == StDone);
   assign err_unexp  = err_unexp_q;

endmodule

// File: tb/tb_sig_req_arbiter.sv
// Bench for sig_req_arbiter: a pipelined stub unit (y = ~x) plus a queue-based
// model of grants, issue, responses and status flags, checked every cycle.
module tb_sig_req_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int IDW  = 2;
   localparam int MAXI = 8;
   localparam int CW   = 4;
   localparam int MRun = 0, MDrain = 1, MDone = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_x;
   logic [NREQ-1:0]      req_ready;
   logic                 drain;
   logic                 sig_start;
   logic [DW-1:0]        sig_x;
   logic [DW-1:0]        sig_y;
   logic                 sig_valid;
   logic                 resp_valid;
   logic [IDW-1:0]       resp_id;
   logic [DW-1:0]        resp_y;
   logic [CW-1:0]        inflight;
   logic                 busy;
   logic                 drain_done;
   logic                 err_unexp;

   sig_req_arbiter #(
      .NREQ(NREQ), .DWIDTH(DW), .IDW(IDW), .MAX_INFLIGHT(MAXI), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
      .drain(drain), .sig_start(sig_start), .sig_x(sig_x), .sig_y(sig_y),
      .sig_valid(sig_valid), .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
      .inflight(inflight), .busy(busy), .drain_done(drain_done), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   // Stub sigmoid unit: fixed latency, fully pipelined, y = ~x; keeps running through reset.
   int            lat = 3;
   logic [31:0]   sp = '0;
   logic [DW-1:0] sy [32];
   logic          inj_v = 1'b0;
   logic [DW-1:0] inj_y = '0;

   always @(posedge clk) begin
      sp    <= {sp[30:0], sig_start};
      sy[0] <= ~sig_x;
      for (int k = 1; k < 32; k++) sy[k] <= sy[k-1];
   end
   assign sig_valid = sp[lat-1] | inj_v;
   assign sig_y     = inj_v ? inj_y : sy[lat-1];

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  x;
   } ent_t;

   ent_t          mq[$];
   int            m_state, m_rr;
   logic          m_start, m_rv, m_err;
   logic [DW-1:0] m_sx, m_ry;
   logic [IDW-1:0] m_rid;

   logic          pend [NREQ];
   logic [DW-1:0] px [NREQ];
   logic          hold_mode;
   int            n_vec = 0;
   int            n_miss = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_state = MRun;
      m_rr    = 0;
      m_start = 1'b0;
      m_rv    = 1'b0;
      m_err   = 1'b0;
      m_sx    = '0;
      m_ry    = '0;
      m_rid   = '0;
   endtask

   // One clock: drive, compare at negedge+1, advance the model, wait to the next negedge.
   task automatic step();
      int              g, sz;
      logic            sv;
      logic [NREQ-1:0] erdy;
      ent_t            e;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = pend[i];
         req_x[i*DW +: DW]  = px[i];
      end
      #1;
      sz = mq.size();
      g  = -1;
      if (m_state == MRun && sz < MAXI)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && pend[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      erdy = '0;
      if (g >= 0) erdy[g] = 1'b1;
      check("req_ready", req_ready, erdy);
      check("sig_start", sig_start, m_start);
      check("sig_x", sig_x, m_sx);
      check("resp_valid", resp_valid, m_rv);
      if (m_rv) begin
         check("resp_id", resp_id, m_rid);
         check("resp_y", resp_y, m_ry);
      end
      check("inflight", inflight, sz);
      check("busy", busy, (sz != 0) || m_start);
      check("drain_done", drain_done, m_state == MDone);
      check("err_unexp", err_unexp, m_err);

      sv = sig_valid;
      case (m_state)
         MRun:   if (drain) m_state = MDrain;
         MDrain: if (!drain) m_state = MRun;
                 else if (sz == 0 && !m_start) m_state = MDone;
         default: if (!drain) m_state = MRun;
      endcase
      m_rv = 1'b0;
      if (sv && sz > 0) begin
         e     = mq.pop_front();
         m_rv  = 1'b1;
         m_rid = e.id;
         m_ry  = ~e.x;
      end
      if (sv && sz == 0) m_err = 1'b1;
      m_start = (g >= 0);
      if (g >= 0) begin
         e.id = IDW'(g);
         e.x  = px[g];
         mq.push_back(e);
         m_sx = px[g];
         m_rr = (g + 1) % NREQ;
         if (!hold_mode) pend[g] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_pend();
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((mq.size() != 0 || m_start || m_rv || sp != '0) && n < 200) begin
         step();
         n++;
      end
      check("idle_timeout", n < 200, 1);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      clear_pend();
      drain     = 1'b0;
      req_valid = '0;
      rst       = 1'b0;
      #1;
      check("rst_sig_start", sig_start, 0);
      check("rst_sig_x", sig_x, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_y", resp_y, 0);
      check("rst_inflight", inflight, 0);
      check("rst_busy", busy, 0);
      check("rst_drain_done", drain_done, 0);
      check("rst_err_unexp", err_unexp, 0);
      check("rst_req_ready", req_ready, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic [DW-1:0] rr_vals [4];
   logic [DW-1:0] sp_vals [4];

   initial begin
      rr_vals = '{32'h3F19999A, 32'h4007AE14, 32'h40B0F5C3, 32'hC0133333};
      sp_vals = '{32'h7F800000, 32'hFF800000, 32'h7FC80000, 32'h00480000};
      rst       = 1'b1;
      drain     = 1'b0;
      req_valid = '0;
      req_x     = '0;
      hold_mode = 1'b0;
      for (int i = 0; i < NREQ; i++) px[i] = '0;
      clear_pend();
      model_reset();
      @(negedge clk);
      do_reset();

      // Single request from requester 0
      px[0] = 32'h3F9D70A4;
      pend[0] = 1'b1;
      step();
      check("single_start", sig_start, 1);
      check("single_sig_x", sig_x, 32'h3F9D70A4);
      repeat (4) step();
      check("single_resp_valid", resp_valid, 1);
      check("single_resp_id", resp_id, 0);
      check("single_resp_y", resp_y, 32'hC0628F5B);
      wait_idle();

      // Round-robin with all requesters continuously valid
      hold_mode = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         px[i]   = rr_vals[i];
         pend[i] = 1'b1;
      end
      repeat (14) step();
      hold_mode = 1'b0;
      clear_pend();
      wait_idle();

      // Credit limit with a slow unit
      lat = 20;
      hold_mode = 1'b1;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
      repeat (9) step();
      check("credit_full", inflight, 8);
      repeat (30) step();
      hold_mode = 1'b0;
      clear_pend();
      wait_idle();

      // Drain with five outstanding operations
      hold_mode = 1'b1;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
      repeat (5) step();
      clear_pend();
      drain = 1'b1;
      step();
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
      step();
      check("drain_busy", busy, 1);
      check("drain_inflight", inflight, 5);
      repeat (28) step();
      check("drain_done_level", drain_done, 1);
      drain = 1'b0;
      repeat (3) step();
      hold_mode = 1'b0;
      clear_pend();
      wait_idle();

      // Special operand values forwarded bit-exact
      lat = 3;
      for (int s = 0; s < 4; s++) begin
         px[2]   = sp_vals[s];
         pend[2] = 1'b1;
         step();
         check("special_sig_x", sig_x, sp_vals[s]);
      end
      wait_idle();

      // Randomized traffic
      lat = 4;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1;
               px[i]   = $urandom;
            end
         step();
      end
      clear_pend();
      wait_idle();

      // Unexpected result with an empty tag FIFO
      inj_y = $urandom;
      inj_v = 1'b1;
      step();
      inj_v = 1'b0;
      step();
      check("unexp_err", err_unexp, 1);
      check("unexp_no_resp", resp_valid, 0);
      check("unexp_inflight", inflight, 0);

      // Reset with three operations in flight; their late results flag an error
      lat = 20;
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      pend[2] = 1'b1;
      px[0] = $urandom;
      px[1] = $urandom;
      px[2] = $urandom;
      repeat (4) step();
      do_reset();
      repeat (25) step();
      check("late_err", err_unexp, 1);
      check("late_inflight", inflight, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
